// File: rtl/prewish5k_pkg.sv
// Shared definitions for the prewish5k button/gesture datapath.
// Event codes are consumed by the blinky pattern controller as well.
package prewish5k_pkg;

  localparam logic [7:0] EV_CLICK    = 8'h01;
  localparam logic [7:0] EV_DOUBLE   = 8'h02;
  localparam logic [7:0] EV_LONG     = 8'h03;
  localparam logic [7:0] EV_LONG_REL = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOWN1 = 3'd1,
    ST_WAIT2 = 3'd2,
    ST_DOWN2 = 3'd3,
    ST_LONGH = 3'd4
  } btn_state_e;

endpackage

// File: rtl/prewish5k_tick_prescaler.sv
// Divides clk by TICK_DIV; tick is a one-cycle pulse on the last count.
// clear restarts the division so a tick lands exactly TICK_DIV clocks later.
module prewish5k_tick_prescaler #(
  parameter int unsigned TICK_DIV = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prewish5k_button_events.sv
// Classifies the debounced button level into click / double / long / long-release
// events, emitted as a single-cycle strobe plus a held event byte.
module prewish5k_button_events
  import prewish5k_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 12000,
  parameter int unsigned LONG_TICKS   = 600,
  parameter int unsigned DCLICK_TICKS = 250,
  parameter int unsigned CNT_W        = 10
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic       o_alive
);

  if (LONG_TICKS > (64'd1 << CNT_W) - 64'd1) begin : g_long_range_chk
    $error("LONG_TICKS does not fit in CNT_W bits");
  end
  if (DCLICK_TICKS > (64'd1 << CNT_W) - 64'd1) begin : g_dclick_range_chk
    $error("DCLICK_TICKS does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LONG_T   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] DCLICK_T = CNT_W'(DCLICK_TICKS);

  btn_state_e       state, state_next;
  logic             lvl;
  logic [CNT_W-1:0] tcnt;
  logic             tick;
  logic             state_chg;
  logic             ev_valid;
  logic [7:0]       ev_code;
  logic             hb_tick;
  logic [8:0]       hb_cnt;
  logic             unused_dat;

  assign unused_dat = ^DAT_I[7:1];
  assign state_chg  = (state_next != state);

  prewish5k_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_fsm_div (
    .clk    (CLK_I),
    .rst_n  (RST_I),
    .clear  (state_chg),
    .enable (1'b1),
    .tick   (tick)
  );

  prewish5k_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_hb_div (
    .clk    (CLK_I),
    .rst_n  (RST_I),
    .clear  (1'b0),
    .enable (1'b1),
    .tick   (hb_tick)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      lvl <= 1'b0;
    end else if (STB_I) begin
      lvl <= DAT_I[0];
    end
  end

  // Level tests come first in every state so a release beats a same-cycle timeout.
  always_comb begin
    state_next = state;
    ev_valid   = 1'b0;
    ev_code    = '0;
    case (state)
      ST_IDLE: begin
        if (lvl) state_next = ST_DOWN1;
      end
      ST_DOWN1: begin
        if (!lvl) begin
          state_next = ST_WAIT2;
        end else if (tcnt == LONG_T) begin
          state_next = ST_LONGH;
          ev_valid   = 1'b1;
          ev_code    = EV_LONG;
        end
      end
      ST_WAIT2: begin
        if (lvl) begin
          state_next = ST_DOWN2;
        end else if (tcnt == DCLICK_T) begin
          state_next = ST_IDLE;
          ev_valid   = 1'b1;
          ev_code    = EV_CLICK;
        end
      end
      ST_DOWN2: begin
        if (!lvl) begin
          state_next = ST_IDLE;
          ev_valid   = 1'b1;
          ev_code    = EV_DOUBLE;
        end else if (tcnt == LONG_T) begin
          state_next = ST_LONGH;
          ev_valid   = 1'b1;
          ev_code    = EV_LONG;
        end
      end
      ST_LONGH: begin
        if (!lvl) begin
          state_next = ST_IDLE;
          ev_valid   = 1'b1;
          ev_code    = EV_LONG_REL;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_next;
      if (state_chg) begin
        tcnt <= '0;
      end else if (tick && (tcnt != '1)) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      STB_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      STB_O <= ev_valid;
      if (ev_valid) DAT_O <= ev_code;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      hb_cnt  <= '0;
      o_alive <= 1'b0;
    end else if (hb_tick) begin
      hb_cnt <= hb_cnt + 1'b1;
      if (hb_cnt == '1) o_alive <= ~o_alive;
    end
  end

endmodule

// File: tb/tb_prewish5k_button_events.sv
// Directed bench for prewish5k_button_events with short tick/threshold parameters.
module tb_prewish5k_button_events;

  logic       CLK_I = 1'b0;
  logic       RST_I;
  logic       STB_I;
  logic [7:0] DAT_I;
  logic       STB_O;
  logic [7:0] DAT_O;
  logic       o_alive;

  typedef struct {
    int         cyc;
    logic [7:0] code;
  } ev_t;

  ev_t evq[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  prewish5k_button_events #(
    .TICK_DIV     (4),
    .LONG_TICKS   (20),
    .DCLICK_TICKS (8),
    .CNT_W        (10)
  ) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .STB_I   (STB_I),
    .DAT_I   (DAT_I),
    .STB_O   (STB_O),
    .DAT_O   (DAT_O),
    .o_alive (o_alive)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc <= cyc + 1;

  // Each entry is stamped with the index of the edge that raised STB_O.
  always @(negedge CLK_I) begin
    if (STB_O) evq.push_back('{cyc: cyc, code: DAT_O});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int e);
    @(negedge CLK_I);
    STB_I = 1'b1;
    DAT_I = b;
    @(posedge CLK_I);
    #1;
    e = cyc;
    STB_I = 1'b0;
  endtask

  task automatic send_at(input int e, input logic lv);
    @(negedge CLK_I);
    while (cyc < e - 1) @(negedge CLK_I);
    STB_I = 1'b1;
    DAT_I = {7'h55, lv};
    @(posedge CLK_I);
    #1;
    STB_I = 1'b0;
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge CLK_I);
  endtask

  task automatic check_one(input string tag, input logic [7:0] code, input int at);
    check({tag, "_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      check({tag, "_code"}, evq[0].code, code);
      check({tag, "_cyc"}, evq[0].cyc, at);
    end
    evq.delete();
  endtask

  initial begin
    int p, r, r1, r2, p2, r0, rise, dummy;

    RST_I = 1'b0;
    STB_I = 1'b0;
    DAT_I = '0;
    repeat (3) @(posedge CLK_I);
    #1;
    check("rst_stb", STB_O, 0);
    check("rst_dat", DAT_O, 8'h00);
    check("rst_alive", o_alive, 0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    repeat (4) @(posedge CLK_I);

    // single click: release after ~5 ticks, CLICK 8 ticks after WAIT2 entry
    send_byte({7'h55, 1'b1}, p);
    r = p + 21;
    send_at(r, 1'b0);
    wait_to(r + 45);
    check_one("click", 8'h01, r + 34);

    // double click: re-press 3 ticks into WAIT2
    send_byte({7'h55, 1'b1}, p);
    r1 = p + 9;
    send_at(r1, 1'b0);
    send_at(r1 + 12, 1'b1);
    r2 = r1 + 20;
    send_at(r2, 1'b0);
    wait_to(r2 + 45);
    check_one("double", 8'h02, r2 + 1);

    // long press then release
    send_byte({7'h55, 1'b1}, p);
    r = p + 101;
    send_at(r, 1'b0);
    wait_to(r + 10);
    check("long_count", evq.size(), 2);
    if (evq.size() == 2) begin
      check("long_code", evq[0].code, 8'h03);
      check("long_cyc", evq[0].cyc, p + 82);
      check("lrel_code", evq[1].code, 8'h04);
      check("lrel_cyc", evq[1].cyc, r + 1);
    end
    evq.delete();

    // unchanged level with junk upper bits
    send_byte(8'hFE, dummy);
    send_byte(8'h54, dummy);
    send_byte(8'hAA, dummy);
    wait_to(cyc + 50);
    check("noop_count", evq.size(), 0);
    check("noop_dat_hold", DAT_O, 8'h04);
    evq.delete();

    // release lands on the same edge tcnt reaches LONG_TICKS
    send_byte({7'h55, 1'b1}, p);
    send_at(p + 81, 1'b0);
    wait_to(p + 125);
    check_one("race", 8'h01, p + 115);

    // reset in the middle of a long hold
    send_byte({7'h55, 1'b1}, p);
    wait_to(p + 90);
    check_one("pre_rst_long", 8'h03, p + 82);
    #2;
    RST_I = 1'b0;
    #1;
    check("async_rst_stb", STB_O, 0);
    check("async_rst_dat", DAT_O, 8'h00);
    check("async_rst_alive", o_alive, 0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    evq.delete();
    send_byte({7'h55, 1'b1}, p2);
    wait_to(p2 + 95);
    check_one("post_rst_long", 8'h03, p2 + 82);

    // heartbeat: first toggle 512 ticks after reset release
    @(negedge CLK_I);
    RST_I = 1'b0;
    @(negedge CLK_I);
    RST_I = 1'b1;
    r0 = cyc;
    rise = -1;
    for (int i = 0; i < 2200; i++) begin
      @(negedge CLK_I);
      if (o_alive) begin
        rise = cyc;
        break;
      end
    end
    check("alive_rise", rise, r0 + 2048);
    check("alive_no_events", evq.size(), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
